interrupt_priority_engine: RTL and testbench

INTERRUPT_PRIORITY_ENGINE -- requirements
Module: interrupt_priority_engine

---
 rtl/ipe_pkg.sv | 54 +++++
 rtl/ipe_resolver.sv | 49 ++++
 rtl/interrupt_priority_engine.sv | 123 ++++++++++++
 tb/tb_interrupt_priority_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipe_pkg.sv
// Shared types and width-generic bit helpers for the interrupt priority engine.
// Helpers operate on a 32-bit container; callers pass the live width (2..32).
package ipe_pkg;

    localparam int unsigned MAX_W = 32;

    typedef logic [MAX_W-1:0] vec_t;

    typedef enum logic {
        TRIG_EDGE  = 1'b0,
        TRIG_LEVEL = 1'b1
    } trig_mode_e;

    // Result bit i takes source bit (i + amt) mod w.
    function automatic vec_t rotate_right(input vec_t v, input int unsigned amt, input int unsigned w);
        vec_t        r;
        int unsigned j;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                j = (i + amt) % w;
                r[i[4:0]] = v[j[4:0]];
            end
        end
        return r;
    endfunction

    function automatic vec_t rotate_left(input vec_t v, input int unsigned amt, input int unsigned w);
        vec_t        r;
        int unsigned j;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                j = (i + amt) % w;
                r[j[4:0]] = v[i[4:0]];
            end
        end
        return r;
    endfunction

    function automatic vec_t lowest_onehot(input vec_t v);
        return v & (~v + vec_t'(1));
    endfunction

    function automatic logic [4:0] onehot_to_bin(input vec_t v);
        logic [4:0] b;
        b = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (v[i[4:0]]) b = b | i[4:0];
        end
        return b;
    endfunction

endpackage

// File: rtl/ipe_resolver.sv
// Combinational priority resolution: request winner, nesting qualification and
// highest in-service channel, all relative to the rotating priority pointer.
module ipe_resolver
    import ipe_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    localparam int ID_W = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] irr,
    input  logic [NUM_IRQ-1:0] interrupt_mask,
    input  logic [NUM_IRQ-1:0] isr,
    input  logic [ID_W-1:0]    lowest_id,
    input  logic               special_mask_mode,
    input  logic               special_fully_nest,
    output logic [ID_W-1:0]    winner_id,
    output logic               winner_valid,
    output logic [ID_W-1:0]    isr_top_id,
    output logic               isr_top_any
);

    int unsigned        base;
    logic [NUM_IRQ-1:0] eff_isr;
    vec_t               req_rot, eff_rot, isr_rot;
    vec_t               req_oh, eff_oh, isr_oh;
    logic [4:0]         req_pos, eff_pos;

    // Rotating right by the highest-priority channel puts it at bit 0, so the
    // lowest set bit of a rotated vector is its highest-priority member.
    always_comb begin
        base    = (32'(lowest_id) + 32'd1) % NUM_IRQ;
        eff_isr = special_mask_mode ? (isr & ~interrupt_mask) : isr;
        req_rot = rotate_right(vec_t'(irr & ~interrupt_mask), base, NUM_IRQ);
        eff_rot = rotate_right(vec_t'(eff_isr), base, NUM_IRQ);
        isr_rot = rotate_right(vec_t'(isr), base, NUM_IRQ);
        req_oh  = lowest_onehot(req_rot);
        eff_oh  = lowest_onehot(eff_rot);
        isr_oh  = lowest_onehot(isr_rot);
        req_pos = onehot_to_bin(req_oh);
        eff_pos = onehot_to_bin(eff_oh);

        winner_id    = ID_W'(onehot_to_bin(rotate_left(req_oh, base, NUM_IRQ)));
        isr_top_id   = ID_W'(onehot_to_bin(rotate_left(isr_oh, base, NUM_IRQ)));
        isr_top_any  = |isr;
        winner_valid = (|req_rot) &&
                       (!(|eff_rot) || (req_pos < eff_pos) ||
                        (special_fully_nest && (req_pos == eff_pos)));
    end

endmodule

// File: rtl/interrupt_priority_engine.sv
// Rotating-priority interrupt controller with IRR/ISR nesting and EOI handling.
// Optional polled acknowledge port set enabled by defining IPE_POLL_EN.
module interrupt_priority_engine
    import ipe_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    localparam int ID_W = $clog2(NUM_IRQ)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               level_trigger,
    input  logic [NUM_IRQ-1:0] interrupt_mask,
    input  logic               special_mask_mode,
    input  logic               special_fully_nest,
    input  logic               auto_rotate,
    output logic               int_req,
    input  logic               int_ack,
    output logic               ack_valid,
    output logic [ID_W-1:0]    ack_id,
    output logic               ack_spurious,
    input  logic               eoi_valid,
    input  logic               eoi_specific,
    input  logic [ID_W-1:0]    eoi_id,
    input  logic               set_priority,
    input  logic [ID_W-1:0]    set_priority_id,
    output logic [NUM_IRQ-1:0] irr,
    output logic [NUM_IRQ-1:0] isr
`ifdef IPE_POLL_EN
    ,
    input  logic               poll_req,
    output logic               poll_valid,
    output logic [ID_W-1:0]    poll_id
`endif
);

    logic [NUM_IRQ-1:0] irq_hist;
    logic               armed;
    logic [ID_W-1:0]    lowest_id;
    logic [ID_W-1:0]    winner_id, isr_top_id, lowest_next;
    logic               winner_valid, isr_top_any;
    logic               ack_evt, take;
    logic [NUM_IRQ-1:0] set_bits, clr_bits, rise, irr_next, isr_next;
    trig_mode_e         mode;

    assign mode = trig_mode_e'(level_trigger);

`ifdef IPE_POLL_EN
    assign ack_evt = int_ack | poll_req;
`else
    assign ack_evt = int_ack;
`endif

    ipe_resolver #(.NUM_IRQ(NUM_IRQ)) u_resolver (
        .irr                (irr),
        .interrupt_mask     (interrupt_mask),
        .isr                (isr),
        .lowest_id          (lowest_id),
        .special_mask_mode  (special_mask_mode),
        .special_fully_nest (special_fully_nest),
        .winner_id          (winner_id),
        .winner_valid       (winner_valid),
        .isr_top_id         (isr_top_id),
        .isr_top_any        (isr_top_any)
    );

    // Edge detection stays disarmed for the first cycle out of reset so a line
    // already high when reset releases is not mistaken for a fresh request.
    always_comb begin
        take     = ack_evt & winner_valid;
        set_bits = take ? (NUM_IRQ'(1) << winner_id) : '0;
        clr_bits = '0;
        if (eoi_valid) begin
            if (eoi_specific)     clr_bits = NUM_IRQ'(1) << eoi_id;
            else if (isr_top_any) clr_bits = NUM_IRQ'(1) << isr_top_id;
        end
        rise     = irq_in & ~irq_hist & {NUM_IRQ{armed}};
        irr_next = (mode == TRIG_LEVEL) ? irq_in : ((irr | rise) & irq_in & ~set_bits);
        isr_next = (isr & ~clr_bits) | set_bits;
        lowest_next = lowest_id;
        if (eoi_valid && !eoi_specific && auto_rotate && isr_top_any) lowest_next = isr_top_id;
        if (set_priority) lowest_next = set_priority_id;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irr          <= '0;
            isr          <= '0;
            irq_hist     <= '0;
            armed        <= 1'b0;
            lowest_id    <= ID_W'(NUM_IRQ - 1);
            int_req      <= 1'b0;
            ack_valid    <= 1'b0;
            ack_id       <= '0;
            ack_spurious <= 1'b0;
        end else begin
            irr       <= irr_next;
            isr       <= isr_next;
            irq_hist  <= irq_in;
            armed     <= 1'b1;
            lowest_id <= lowest_next;
            int_req   <= winner_valid;
            ack_valid <= int_ack;
            if (int_ack) begin
                ack_id       <= winner_valid ? winner_id : ID_W'(NUM_IRQ - 1);
                ack_spurious <= ~winner_valid;
            end
        end
    end

`ifdef IPE_POLL_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            poll_valid <= 1'b0;
            poll_id    <= '0;
        end else begin
            poll_valid <= poll_req;
            if (poll_req) poll_id <= winner_valid ? winner_id : ID_W'(NUM_IRQ - 1);
        end
    end
`endif

endmodule

// File: tb/tb_interrupt_priority_engine.sv
// Scenario bench for interrupt_priority_engine (default build, NUM_IRQ = 8).
// Acknowledge results are scored through an expectation queue.
module tb_interrupt_priority_engine;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] irq_in;
    logic       level_trigger;
    logic [7:0] interrupt_mask;
    logic       special_mask_mode;
    logic       special_fully_nest;
    logic       auto_rotate;
    logic       int_req;
    logic       int_ack;
    logic       ack_valid;
    logic [2:0] ack_id;
    logic       ack_spurious;
    logic       eoi_valid;
    logic       eoi_specific;
    logic [2:0] eoi_id;
    logic       set_priority;
    logic [2:0] set_priority_id;
    logic [7:0] irr;
    logic [7:0] isr;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];   // {spurious, id}
    logic [3:0] mon_exp;

    always #5 clock = ~clock;

    interrupt_priority_engine #(.NUM_IRQ(8)) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .irq_in             (irq_in),
        .level_trigger      (level_trigger),
        .interrupt_mask     (interrupt_mask),
        .special_mask_mode  (special_mask_mode),
        .special_fully_nest (special_fully_nest),
        .auto_rotate        (auto_rotate),
        .int_req            (int_req),
        .int_ack            (int_ack),
        .ack_valid          (ack_valid),
        .ack_id             (ack_id),
        .ack_spurious       (ack_spurious),
        .eoi_valid          (eoi_valid),
        .eoi_specific       (eoi_specific),
        .eoi_id             (eoi_id),
        .set_priority       (set_priority),
        .set_priority_id    (set_priority_id),
        .irr                (irr),
        .isr                (isr)
    );

    // Acknowledge responses are popped from the queue as they appear.
    always @(posedge clock) begin
        #1;
        if (ack_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected: ack_id=%0d spurious=%0b with nothing expected", ack_id, ack_spurious);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({ack_spurious, ack_id} !== mon_exp) begin
                    errors++;
                    $display("FAIL ack_response: id=%0d spurious=%0b expected id=%0d spurious=%0b",
                             ack_id, ack_spurious, mon_exp[2:0], mon_exp[3]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ack(input logic spur, input logic [2:0] id);
        int_ack = 1'b1;
        exp_q.push_back({spur, id});
        tick();
        int_ack = 1'b0;
    endtask

    task automatic eoi(input logic specific, input logic [2:0] id);
        eoi_valid = 1'b1; eoi_specific = specific; eoi_id = id;
        tick();
        eoi_valid = 1'b0; eoi_specific = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; irq_in = '0; level_trigger = 1'b0; interrupt_mask = '0;
        special_mask_mode = 1'b0; special_fully_nest = 1'b0; auto_rotate = 1'b0;
        int_ack = 1'b0; eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_id = '0;
        set_priority = 1'b0; set_priority_id = '0;
        #2;
        checks++; if (irr !== 8'h00) begin errors++; $display("FAIL reset_irr: got %h expected 00", irr); end
        checks++; if (isr !== 8'h00) begin errors++; $display("FAIL reset_isr: got %h expected 00", isr); end
        checks++; if ({int_req, ack_valid, ack_spurious} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: int_req/ack_valid/spurious=%b expected 000", {int_req, ack_valid, ack_spurious}); end
        checks++; if (ack_id !== 3'd0) begin errors++; $display("FAIL reset_ack_id: got %0d expected 0", ack_id); end
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_edge();
        irq_in = 8'h08;
        tick();
        checks++; if (irr !== 8'h08) begin errors++; $display("FAIL edge_irr_set: got %h expected 08", irr); end
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL edge_latency1: int_req=%b expected 0", int_req); end
        tick();
        checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL edge_latency2: int_req=%b expected 1", int_req); end
        ack(1'b0, 3'd3);
        checks++; if (isr !== 8'h08) begin errors++; $display("FAIL edge_isr: got %h expected 08", isr); end
        checks++; if (irr !== 8'h00) begin errors++; $display("FAIL edge_irr_clr: got %h expected 00", irr); end
    endtask

    task automatic test_nesting();
        irq_in = 8'h28;
        tick(); tick();
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL nest_lower_blocked: int_req=%b expected 0", int_req); end
        irq_in = 8'h2A;
        tick(); tick();
        checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL nest_higher_req: int_req=%b expected 1", int_req); end
        ack(1'b0, 3'd1);
        checks++; if (isr !== 8'h0A) begin errors++; $display("FAIL nest_isr: got %h expected 0a", isr); end
        checks++; if (irr !== 8'h20) begin errors++; $display("FAIL nest_irr: got %h expected 20", irr); end
        irq_in = '0;
        eoi(1'b1, 3'd1);
        eoi(1'b1, 3'd3);
        checks++; if (isr !== 8'h00) begin errors++; $display("FAIL nest_specific_eoi: isr=%h expected 00", isr); end
    endtask

    task automatic test_rotate();
        irq_in = 8'h04;
        tick(); tick();
        ack(1'b0, 3'd2);
        checks++; if (isr !== 8'h04) begin errors++; $display("FAIL rot_isr_set: got %h expected 04", isr); end
        irq_in = '0; auto_rotate = 1'b1;
        eoi(1'b0, 3'd0);
        checks++; if (isr !== 8'h00) begin errors++; $display("FAIL rot_eoi_clear: isr=%h expected 00", isr); end
        irq_in = 8'h0C;
        tick(); tick();
        ack(1'b0, 3'd3);
        checks++; if (isr !== 8'h08) begin errors++; $display("FAIL rot_winner_isr: got %h expected 08", isr); end
        // set_priority must beat the auto-rotation to 3 on the same edge
        irq_in = '0; set_priority = 1'b1; set_priority_id = 3'd7;
        eoi(1'b0, 3'd0);
        set_priority = 1'b0; auto_rotate = 1'b0;
        checks++; if ({irr, isr} !== 16'h0000) begin errors++; $display("FAIL rot_cleanup: irr/isr=%h expected 0000", {irr, isr}); end
        irq_in = 8'h11;
        tick(); tick();
        ack(1'b0, 3'd0);
        checks++; if (isr !== 8'h01) begin errors++; $display("FAIL setprio_wins: isr=%h expected 01", isr); end
    endtask

    task automatic test_spurious();
        ack(1'b1, 3'd7);
        checks++; if (isr !== 8'h01) begin errors++; $display("FAIL spur_isr_kept: got %h expected 01", isr); end
        checks++; if (irr !== 8'h10) begin errors++; $display("FAIL spur_irr_kept: got %h expected 10", irr); end
        irq_in = '0;
        eoi(1'b1, 3'd0);
        ack(1'b1, 3'd7);
        checks++; if ({irr, isr} !== 16'h0000) begin errors++; $display("FAIL spur_empty: irr/isr=%h expected 0000", {irr, isr}); end
    endtask

    task automatic test_fully_nest();
        irq_in = 8'h10;
        tick(); tick();
        ack(1'b0, 3'd4);
        checks++; if (isr !== 8'h10) begin errors++; $display("FAIL sfn_isr: got %h expected 10", isr); end
        irq_in = '0; tick();
        irq_in = 8'h10; tick();
        checks++; if (irr !== 8'h10) begin errors++; $display("FAIL sfn_reedge: irr=%h expected 10", irr); end
        tick();
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL sfn_off: int_req=%b expected 0", int_req); end
        special_fully_nest = 1'b1;
        tick();
        checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL sfn_on: int_req=%b expected 1", int_req); end
        irq_in = '0; special_fully_nest = 1'b0;
        eoi(1'b1, 3'd4);
    endtask

    task automatic test_same_cycle();
        irq_in = 8'h04;
        tick(); tick();
        ack(1'b0, 3'd2);
        irq_in = '0; tick();
        irq_in = 8'h04; tick();
        special_fully_nest = 1'b1;
        eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_id = 3'd2;
        ack(1'b0, 3'd2);
        eoi_valid = 1'b0; eoi_specific = 1'b0;
        checks++; if (isr !== 8'h04) begin errors++; $display("FAIL same_cycle_set_wins: isr=%h expected 04", isr); end
        checks++; if (irr !== 8'h00) begin errors++; $display("FAIL same_cycle_irr: got %h expected 00", irr); end
        irq_in = '0; special_fully_nest = 1'b0;
        eoi(1'b1, 3'd2);
    endtask

    task automatic test_back_to_back();
        irq_in = 8'h42;
        tick(); tick();
        ack(1'b0, 3'd1);
        ack(1'b1, 3'd7);
        checks++; if (isr !== 8'h02) begin errors++; $display("FAIL b2b_isr: got %h expected 02", isr); end
        checks++; if (irr !== 8'h40) begin errors++; $display("FAIL b2b_irr: got %h expected 40", irr); end
    endtask

    task automatic test_level_mask();
        level_trigger = 1'b1; irq_in = 8'h20;
        tick();
        checks++; if (irr !== 8'h20) begin errors++; $display("FAIL level_load: irr=%h expected 20", irr); end
        tick();
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL level_nested: int_req=%b expected 0", int_req); end
        interrupt_mask = 8'h02; special_mask_mode = 1'b1;
        tick();
        checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL smm_unblock: int_req=%b expected 1", int_req); end
        ack(1'b0, 3'd5);
        checks++; if ({irr, isr} !== 16'h2022) begin errors++; $display("FAIL level_ack: irr/isr=%h expected 2022", {irr, isr}); end
        interrupt_mask = 8'h20;
        tick(); tick();
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL mask_blocks: int_req=%b expected 0", int_req); end
        irq_in = '0; level_trigger = 1'b0; interrupt_mask = '0; special_mask_mode = 1'b0;
        eoi(1'b0, 3'd0);
        checks++; if (isr !== 8'h20) begin errors++; $display("FAIL nonspec_top: isr=%h expected 20", isr); end
        eoi(1'b0, 3'd0);
    endtask

    task automatic test_reset_mid();
        irq_in = 8'h01;
        tick(); tick();
        reset_n = 1'b0;
        #1;
        checks++; if ({irr, isr, int_req} !== 17'h0) begin errors++; $display("FAIL async_reset: irr/isr/int_req=%h expected 0", {irr, isr, int_req}); end
        tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        checks++; if ({irr, int_req} !== 9'h0) begin errors++; $display("FAIL held_high_ignored: irr/int_req=%h expected 0", {irr, int_req}); end
        irq_in = '0; tick();
        irq_in = 8'h81; tick();
        checks++; if (irr !== 8'h81) begin errors++; $display("FAIL fresh_edge: irr=%h expected 81", irr); end
        tick();
        ack(1'b0, 3'd0);
        checks++; if (isr !== 8'h01) begin errors++; $display("FAIL reset_priority: isr=%h expected 01", isr); end
    endtask

    initial begin
        test_reset();
        test_edge();
        test_nesting();
        test_rotate();
        test_spurious();
        test_fully_nest();
        test_same_cycle();
        test_back_to_back();
        test_level_mask();
        test_reset_mid();
        tick(); tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL ack_missing: %0d responses outstanding expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
